// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and ALU control words.
package mult_seq_pkg;

    localparam int W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Field order matches the control word bit order zx nx zy ny f no.
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctl_t;

    localparam alu_ctl_t ALU_ZERO  = 6'b101000;
    localparam alu_ctl_t ALU_ADD   = 6'b000010;
    localparam alu_ctl_t ALU_PASSX = 6'b001100;

endpackage

// File: rtl/mult_seq_alu.sv
// Six-control-bit ALU (zero/negate each input, add or AND, negate output)
// with zr/ng flags. The adder is an explicit ripple-carry chain.
module mult_seq_alu
    import mult_seq_pkg::*;
(
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  alu_ctl_t     ctl,
    output logic [W-1:0] out,
    output logic         zr,
    output logic         ng
);

    logic [W-1:0] xz, xn, yz, yn;
    logic [W-1:0] sum, andv, fo;
    logic [W-1:0] carry;

    assign xz = ctl.zx ? '0 : x;
    assign xn = ctl.nx ? ~xz : xz;
    assign yz = ctl.zy ? '0 : y;
    assign yn = ctl.ny ? ~yz : yz;

    assign carry[0] = 1'b0;

    generate
        for (genvar i = 0; i < W; i++) begin : g_rca
            assign sum[i] = xn[i] ^ yn[i] ^ carry[i];
            // Carry out of the top bit is dropped: results wrap modulo 2^W.
            if (i < W - 1) begin : g_c
                assign carry[i+1] = (xn[i] & yn[i]) | (carry[i] & (xn[i] ^ yn[i]));
            end
        end
    endgenerate

    assign andv = xn & yn;
    assign fo   = ctl.f ? sum : andv;
    assign out  = ctl.no ? ~fo : fo;
    assign zr   = (out == '0);
    assign ng   = out[W-1];

endmodule

// File: rtl/mult_seq.sv
// Sequential 16x16 unsigned multiplier (low 16 bits of the product),
// one shift-and-add step per cycle, all arithmetic done by the shared ALU.
module mult_seq
    import mult_seq_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  product,
    output logic          zr,
    output logic          ng
);

    state_t       state;
    logic [W-1:0] acc, mcand, mplier;
    logic [W-1:0] mcand_shl, mplier_shr;
    alu_ctl_t     ctl;
    logic [W-1:0] alu_out;
    logic         alu_zr, alu_ng;

    assign mcand_shl  = {mcand[W-2:0], 1'b0};
    assign mplier_shr = {1'b0, mplier[W-1:1]};

    // LOAD clears acc through the ALU; RUN adds or passes acc through.
    always_comb begin
        ctl = ALU_ZERO;
        if (state == RUN)
            ctl = mplier[0] ? ALU_ADD : ALU_PASSX;
    end

    mult_seq_alu u_alu (
        .x   (acc),
        .y   (mcand),
        .ctl (ctl),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            zr      <= 1'b1;
            ng      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end else begin
                        state  <= IDLE;
                    end
                end
                LOAD: begin
                    acc   <= alu_out;
                    state <= RUN;
                end
                RUN: begin
                    acc    <= alu_out;
                    mcand  <= mcand_shl;
                    mplier <= mplier_shr;
                    // Finish as soon as no multiplier bits remain.
                    if (mplier_shr == '0) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= alu_out;
                        zr      <= alu_zr;
                        ng      <= alu_ng;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed vector table, randomized
// operations against an arithmetic model, and multi-cycle corner sequences.
module tb_mult_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] a, b;
    logic        busy, done, zr, ng;
    logic [15:0] product;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        logic        zr;
        logic        ng;
        int          k;
    } vec_t;

    vec_t vecs[5];

    mult_seq dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zr      (zr),
        .ng      (ng)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic int model_k(input logic [15:0] bv);
        int k = 1;
        for (int i = 0; i < 16; i++)
            if (bv[i]) k = i + 1;
        return k;
    endfunction

    function automatic logic [15:0] model_p(input logic [15:0] av, input logic [15:0] bv);
        longint unsigned full;
        full = longint'(av) * longint'(bv);
        return full[15:0];
    endfunction

    // Drive a start so that it is sampled at the next rising edge (edge 0).
    task automatic issue(input logic [15:0] av, input logic [15:0] bv);
        @(negedge clock);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    // Wait for done counting edges from edge 0; optionally poke start mid-run
    // or chain a new start into the DONE cycle.
    task automatic wait_result(input string name, input logic [15:0] ep, input int k,
                               input bit poke, input bit chain,
                               input logic [15:0] na, input logic [15:0] nb);
        bit seen = 0;
        bit busy_ok = 1;
        for (int n = 1; n <= 40 && !seen; n++) begin
            if (poke && n == 3) begin
                start = 1'b1;
                a = 16'($urandom);
                b = 16'($urandom);
            end
            if (poke && n == 4) start = 1'b0;
            @(posedge clock);
            #1;
            if (done) begin
                seen = 1;
                chk({name, "_latency"}, n, k + 1);
                chk({name, "_product"}, product, ep);
                chk({name, "_zr"}, zr, (ep == 16'h0));
                chk({name, "_ng"}, ng, ep[15]);
                chk({name, "_busy_window"}, busy_ok, 1);
                if (chain) begin
                    a = na;
                    b = nb;
                    start = 1'b1;
                end else begin
                    @(posedge clock);
                    #1;
                    chk({name, "_done_pulse"}, done, 0);
                    chk({name, "_idle_busy"}, busy, 0);
                    chk({name, "_hold"}, product, ep);
                end
            end else if (busy !== 1'b1) begin
                busy_ok = 0;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got=no_done want=done", name);
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [31:0] mask;
        logic [15:0] p2;

        vecs[0] = '{16'd3,     16'd5,      16'd15,     1'b0, 1'b0, 3};
        vecs[1] = '{16'h1234,  16'h0000,   16'h0000,   1'b1, 1'b0, 1};
        vecs[2] = '{16'h0001,  16'hFFFF,   16'hFFFF,   1'b0, 1'b1, 16};
        vecs[3] = '{16'hFFFF,  16'h0002,   16'hFFFE,   1'b0, 1'b1, 2};
        vecs[4] = '{16'h0100,  16'h0100,   16'h0000,   1'b1, 1'b0, 9};

        // Reset with start held high: start must be ignored.
        reset_n = 1'b0;
        start = 1'b1;
        a = 16'h00AA;
        b = 16'h0055;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_product", product, 16'h0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_zr", zr, 1);
        chk("rst_ng", ng, 0);
        start = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("post_rst_idle", {busy, done}, 2'b00);

        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].a, vecs[i].b);
            wait_result($sformatf("vec%0d", i), vecs[i].p, vecs[i].k, 0, 0, 0, 0);
            chk($sformatf("vec%0d_zr_tbl", i), zr, vecs[i].zr);
            chk($sformatf("vec%0d_ng_tbl", i), ng, vecs[i].ng);
        end

        // Start pulsed during RUN must not disturb the running operation.
        issue(16'd100, 16'h00F0);
        wait_result("poke", 16'd24000, 8, 1, 0, 0, 0);

        // Back-to-back: start held in DONE goes straight to LOAD.
        issue(16'd3, 16'd5);
        wait_result("b2b_first", 16'd15, 3, 0, 1, 16'd1000, 16'd77);
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("b2b_load_busy", busy, 1);
        chk("b2b_load_done", done, 0);
        wait_result("b2b_second", model_p(16'd1000, 16'd77), model_k(16'd77), 0, 0, 0, 0);

        // Reset in the 4th RUN cycle (edge 5) aborts without a done pulse.
        issue(16'd7, 16'h00FF);
        repeat (4) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_product", product, 16'h0);
        chk("abort_done", done, 0);
        begin
            bit any_done = 0;
            repeat (12) begin
                @(posedge clock);
                #1;
                if (done) any_done = 1;
            end
            chk("abort_no_done", any_done, 0);
        end
        issue(16'd7, 16'h00FF);
        wait_result("after_abort", 16'd1785, 8, 0, 0, 0, 0);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            mask = (32'h1 << $urandom_range(0, 16)) - 32'h1;
            rb = 16'($urandom & mask);
            p2 = model_p(ra, rb);
            issue(ra, rb);
            wait_result($sformatf("rnd%0d_%h_%h", i, ra, rb), p2, model_k(rb), 0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have no parameters; data width is fixed at 16.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request a multiply; sampled only in IDLE or DONE.
REQ-005 a  input  16  multiplicand; captured on an accepted start.
REQ-006 b  input  16  multiplier; captured on an accepted start.
REQ-007 busy  output  1  high while in LOAD or RUN.
REQ-008 done  output  1  one-cycle pulse when product becomes valid.
REQ-009 product  output  16  low 16 bits of a*b (unsigned); held until the next accepted start.
REQ-010 zr  output  1  the ALU zr flag of the final product.
REQ-011 ng  output  1  the ALU ng flag of the final product (product[15]).

Function
REQ-012 SHALL be an FSM with states IDLE, LOAD, RUN and DONE.
REQ-013 IDLE or DONE with start=1: latch a into mcand and b into mplier, then go to LOAD.
REQ-014 LOAD: clear acc to 0 through the ALU with control zx=1 nx=0 zy=1 ny=0 f=0 no=0, then go to RUN.
REQ-015 Each RUN cycle, when mplier[0]=1: acc <= ALU(x=acc, y=mcand) with control 000010 (x+y).
REQ-016 Each RUN cycle, when mplier[0]=0: acc <= ALU pass-x with control 001100 (x&0xFFFF).
REQ-017 Each RUN cycle SHALL also do mcand <= mcand<<1 (zero fill) and mplier <= mplier>>1 (zero fill).
REQ-018 RUN -> DONE when the shifted mplier is 0; otherwise stay in RUN.
REQ-019 RUN lasts k = max(1, index of highest set bit of b + 1) cycles, so k ranges 1..16.
REQ-020 Latency: start sampled at edge 0, LOAD at edge 1, RUN at edges 2..k+1, done=1 during the cycle after edge k+1.
REQ-021 DONE lasts exactly one cycle; it goes to IDLE unless start=1, in which case it goes to LOAD (back-to-back operation).
REQ-022 start while busy SHALL be ignored, with no queuing and no effect on the running operation.
REQ-023 product, zr and ng SHALL update only on entry to DONE and hold through IDLE.
REQ-024 Overflow above bit 15 SHALL be discarded silently (modulo 2^16); there is no overflow flag.
REQ-025 a and b SHALL be don't-care after capture; changing them mid-operation has no effect.

Reset
REQ-026 reset_n=0 at a rising edge: state=IDLE, acc=0, mcand=0, mplier=0.
REQ-027 reset_n=0 at a rising edge: product=0, done=0, busy=0, zr=1, ng=0.
REQ-028 Reset asserted mid-operation SHALL abort it with no done pulse; product is 0 afterwards.
REQ-029 start sampled in the same cycle as reset_n=0 SHALL be ignored.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (2 bits) and the ALU control constants.
REQ-031 The ALU control constants are ALU_ZERO=101000, ALU_ADD=000010 and ALU_PASSX=001100, in order zx nx zy ny f no.
REQ-032 The ALU SHALL be instantiated once as the only sub-module; it performs all additions and clears.
REQ-033 No behavioural '+' is allowed on the datapath.
REQ-034 The shifts SHALL be plain rewiring.

Verification
REQ-035 a=3, b=5 -> done pulses 5 cycles after the start edge (k=3); product=15, zr=0, ng=0.
REQ-036 a=0x1234, b=0 -> k=1, done 3 cycles after start; product=0, zr=1.
REQ-037 a=1, b=0xFFFF -> k=16, done 18 cycles after start; product=0xFFFF, ng=1.
REQ-038 Overflow: a=0xFFFF, b=2 -> product=0xFFFE, ng=1.
REQ-039 Overflow: a=0x0100, b=0x0100 -> product=0x0000, zr=1.
REQ-040 start pulsed during RUN is ignored, and the result is unchanged.
REQ-041 start=1 in DONE: the next operation enters LOAD with no IDLE cycle, and both products are correct.
REQ-042 reset_n=0 in the 4th RUN cycle of a=7, b=0x00FF -> no done pulse; busy=0 and product=0 next cycle; a following start works.
